// File: rtl/mem_wb_stage_pkg.sv
// rtl/mem_wb_stage_pkg.sv - shared write-back constants: load funct3 codes and reset/enable levels
package mem_wb_stage_pkg;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;

    localparam logic WRITE_ENABLE = 1'b1;
    localparam logic RST_ENABLE   = 1'b1;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// rtl/mem_wb_stage_load_align.sv - load byte/halfword extraction with sign/zero extension
module mem_wb_stage_load_align
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] data_i,
    input  logic [2:0]        type_i,
    input  logic [1:0]        off_i,
    output logic [DATA_W-1:0] data_o,
    output logic              bad_o
);

    // Bring the addressed byte/halfword down to bit 0 before extension.
    logic [15:0] low16;
    assign low16 = 16'(data_i >> {off_i, 3'b000});

    always_comb begin
        data_o = '0;
        bad_o  = 1'b0;
        unique case (type_i)
            FUNCT3_LB:  data_o = {{(DATA_W-8){low16[7]}}, low16[7:0]};
            FUNCT3_LBU: data_o = {{(DATA_W-8){1'b0}}, low16[7:0]};
            FUNCT3_LH: begin
                if (off_i[0]) bad_o = 1'b1;
                else          data_o = {{(DATA_W-16){low16[15]}}, low16};
            end
            FUNCT3_LHU: begin
                if (off_i[0]) bad_o = 1'b1;
                else          data_o = {{(DATA_W-16){1'b0}}, low16};
            end
            FUNCT3_LW: begin
                if (off_i != 2'b00) bad_o = 1'b1;
                else                data_o = data_i;
            end
            default: bad_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - write-back stage: 2-entry retire FIFO feeding the regfile write port
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inValid,
    output logic              inReady,
    input  logic              inWrEn,
    input  logic [ADDR_W-1:0] inRegAddr,
    input  logic [DATA_W-1:0] inData,
    input  logic              inIsLoad,
    input  logic [2:0]        inLoadType,
    input  logic [1:0]        inByteOff,
    input  logic              hold,
    output logic              wEnable,
    output logic [ADDR_W-1:0] wAddr,
    output logic [DATA_W-1:0] wData,
    output logic [CNT_W-1:0]  instret,
    output logic              loadMisalign
);

    logic [DATA_W-1:0] data_q [2];
    logic [ADDR_W-1:0] addr_q [2];
    logic              wr_en_q [2];
    logic              bad_q [2];
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        count_q, count_d;
    logic [CNT_W-1:0]  instret_q;
    logic              misalign_q;

    logic [DATA_W-1:0] fmt_data;
    logic              fmt_bad;
    logic              push, pop;

    mem_wb_stage_load_align #(.DATA_W(DATA_W)) u_load_align (
        .data_i (inData),
        .type_i (inLoadType),
        .off_i  (inByteOff),
        .data_o (fmt_data),
        .bad_o  (fmt_bad)
    );

    // Ready is a pure function of registered occupancy so upstream sees no loop.
    assign inReady = (count_q != 2'd2);
    assign push    = inValid && inReady;
    assign pop     = (count_q != 2'd0) && !hold;

    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + 2'd1;
        else if (pop && !push) count_d = count_q - 2'd1;
    end

    assign wEnable = pop && (wr_en_q[rd_ptr_q] == WRITE_ENABLE)
                     && (addr_q[rd_ptr_q] != '0) && !bad_q[rd_ptr_q];
    assign wAddr   = (count_q != 2'd0) ? addr_q[rd_ptr_q] : '0;
    assign wData   = (count_q != 2'd0) ? data_q[rd_ptr_q] : '0;
    assign instret      = instret_q;
    assign loadMisalign = misalign_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            for (int i = 0; i < 2; i++) begin
                data_q[i]  <= '0;
                addr_q[i]  <= '0;
                wr_en_q[i] <= 1'b0;
                bad_q[i]   <= 1'b0;
            end
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            instret_q  <= '0;
            misalign_q <= 1'b0;
        end else begin
            if (push) begin
                data_q[wr_ptr_q]  <= inIsLoad ? fmt_data : inData;
                bad_q[wr_ptr_q]   <= inIsLoad && fmt_bad;
                addr_q[wr_ptr_q]  <= inRegAddr;
                wr_en_q[wr_ptr_q] <= inWrEn;
                wr_ptr_q          <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q  <= ~rd_ptr_q;
                instret_q <= instret_q + CNT_W'(1);
                if (bad_q[rd_ptr_q]) misalign_q <= 1'b1;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - self-checking bench for mem_wb_stage
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        inValid, inReady, inWrEn, inIsLoad, hold;
    logic [4:0]  inRegAddr, wAddr;
    logic [31:0] inData, wData, instret;
    logic [2:0]  inLoadType;
    logic [1:0]  inByteOff;
    logic        wEnable, loadMisalign;

    mem_wb_stage dut (
        .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady),
        .inWrEn(inWrEn), .inRegAddr(inRegAddr), .inData(inData),
        .inIsLoad(inIsLoad), .inLoadType(inLoadType), .inByteOff(inByteOff),
        .hold(hold), .wEnable(wEnable), .wAddr(wAddr), .wData(wData),
        .instret(instret), .loadMisalign(loadMisalign)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        bad;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_instret;
    logic        m_mis;

    logic        s_ready, s_we;
    logic [4:0]  s_addr;
    logic [31:0] s_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference load formatting written from the ISA rules: {bad, data}.
    function automatic logic [32:0] ref_fmt(logic isl, logic [2:0] lt, logic [1:0] off, logic [31:0] d);
        logic [31:0] s;
        int unsigned b, h;
        if (!isl) return {1'b0, d};
        s = d >> (8 * off);
        b = s & 32'hFF;
        h = s & 32'hFFFF;
        case (lt)
            3'd0: return {1'b0, (b >= 128) ? b - 256 : b};
            3'd4: return {1'b0, 32'(b)};
            3'd1: return (off % 2 != 0) ? {1'b1, 32'h0} : {1'b0, (h >= 32768) ? h - 65536 : h};
            3'd5: return (off % 2 != 0) ? {1'b1, 32'h0} : {1'b0, 32'(h)};
            3'd2: return (off != 0) ? {1'b1, 32'h0} : {1'b0, d};
            default: return {1'b1, 32'h0};
        endcase
    endfunction

    // One clock: drive after the falling edge, check before the rising edge, advance the model.
    task automatic cycle(input logic v, input logic wr, input logic [4:0] a, input logic [31:0] d,
                         input logic isl, input logic [2:0] lt, input logic [1:0] off, input logic h);
        logic        exp_we, do_pop, do_push;
        logic [32:0] f;
        ent_t        e;
        inValid = v; inWrEn = wr; inRegAddr = a; inData = d;
        inIsLoad = isl; inLoadType = lt; inByteOff = off; hold = h;
        #1;
        s_ready = inReady; s_we = wEnable; s_addr = wAddr; s_data = wData;
        do_pop  = (mq.size() > 0) && !h;
        do_push = v && (mq.size() != 2);
        exp_we  = do_pop && mq[0].wr && (mq[0].addr != 0) && !mq[0].bad;
        chk("inReady", {31'b0, inReady}, {31'b0, mq.size() != 2});
        chk("wEnable", {31'b0, wEnable}, {31'b0, exp_we});
        chk("wAddr", {27'b0, wAddr}, (mq.size() > 0) ? {27'b0, mq[0].addr} : 32'h0);
        chk("wData", wData, (mq.size() > 0) ? mq[0].data : 32'h0);
        chk("instret", instret, m_instret);
        chk("loadMisalign", {31'b0, loadMisalign}, {31'b0, m_mis});
        @(posedge clk);
        if (do_pop) begin
            e = mq.pop_front();
            m_instret++;
            if (e.bad) m_mis = 1'b1;
        end
        if (do_push) begin
            f = ref_fmt(isl, lt, off, d);
            e.wr = wr; e.addr = a; e.data = f[31:0]; e.bad = f[32];
            mq.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic h);
        cycle(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 3'd0, 2'd0, h);
    endtask

    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        isl;
        logic [2:0]  lt;
        logic [1:0]  off;
        logic        exp_we;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 3'd7, 2'd3, 1'b1, 32'hDEADBEEF};
        vecs[1]  = '{1'b1, 5'd7, 32'h80F07F81, 1'b1, 3'd0, 2'd0, 1'b1, 32'hFFFFFF81};
        vecs[2]  = '{1'b1, 5'd7, 32'h80F07F81, 1'b1, 3'd4, 2'd3, 1'b1, 32'h00000080};
        vecs[3]  = '{1'b1, 5'd7, 32'h80F07F81, 1'b1, 3'd1, 2'd2, 1'b1, 32'hFFFF80F0};
        vecs[4]  = '{1'b1, 5'd7, 32'h80F07F81, 1'b1, 3'd5, 2'd0, 1'b1, 32'h00007F81};
        vecs[5]  = '{1'b1, 5'd7, 32'h80F07F81, 1'b1, 3'd2, 2'd1, 1'b0, 32'h00000000};
        vecs[6]  = '{1'b1, 5'd9, 32'h80F07F81, 1'b1, 3'd2, 2'd0, 1'b1, 32'h80F07F81};
        vecs[7]  = '{1'b1, 5'd9, 32'h80F07F81, 1'b1, 3'd0, 2'd1, 1'b1, 32'h0000007F};
        vecs[8]  = '{1'b1, 5'd9, 32'h80F07F81, 1'b1, 3'd1, 2'd3, 1'b0, 32'h00000000};
        vecs[9]  = '{1'b1, 5'd0, 32'h12345678, 1'b0, 3'd0, 2'd0, 1'b0, 32'h12345678};
        vecs[10] = '{1'b0, 5'd3, 32'h0000ABCD, 1'b0, 3'd0, 2'd0, 1'b0, 32'h0000ABCD};

        rst = 1'b1; inValid = 0; inWrEn = 0; inRegAddr = 0; inData = 0;
        inIsLoad = 0; inLoadType = 0; inByteOff = 0; hold = 0;
        m_instret = 0; m_mis = 0;
        repeat (2) @(negedge clk);
        chk("reset_ready", {31'b0, inReady}, 32'd1);
        chk("reset_we", {31'b0, wEnable}, 32'd0);
        chk("reset_instret", instret, 32'd0);
        chk("reset_mis", {31'b0, loadMisalign}, 32'd0);
        rst = 1'b0;

        // Table: each entry pushed into an empty FIFO, written on the next cycle.
        for (int i = 0; i < 11; i++) begin
            cycle(1'b1, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].isl,
                  vecs[i].lt, vecs[i].off, 1'b0);
            idle(1'b0);
            chk($sformatf("vec%0d_we", i), {31'b0, s_we}, {31'b0, vecs[i].exp_we});
            chk($sformatf("vec%0d_addr", i), {27'b0, s_addr}, {27'b0, vecs[i].addr});
            chk($sformatf("vec%0d_data", i), s_data, vecs[i].exp_data);
        end
        idle(1'b0);
        chk("table_instret", instret, 32'd11);
        chk("table_mis", {31'b0, loadMisalign}, 32'd1);

        // Hold with three back-to-back pushes, then drain in order.
        cycle(1'b1, 1'b1, 5'd10, 32'hA, 1'b0, 3'd0, 2'd0, 1'b1);
        cycle(1'b1, 1'b1, 5'd11, 32'hB, 1'b0, 3'd0, 2'd0, 1'b1);
        cycle(1'b1, 1'b1, 5'd12, 32'hC, 1'b0, 3'd0, 2'd0, 1'b1);
        chk("hold_full_ready", {31'b0, s_ready}, 32'd0);
        repeat (3) idle(1'b1);
        idle(1'b0);
        chk("drain1_we", {31'b0, s_we}, 32'd1);
        chk("drain1_addr", {27'b0, s_addr}, 32'd10);
        idle(1'b0);
        chk("drain2_ready", {31'b0, s_ready}, 32'd1);
        chk("drain2_addr", {27'b0, s_addr}, 32'd11);
        chk("drain2_data", s_data, 32'hB);
        idle(1'b0);
        chk("drained_we", {31'b0, s_we}, 32'd0);

        // Reset mid-operation with two buffered entries.
        cycle(1'b1, 1'b1, 5'd20, 32'h55, 1'b0, 3'd0, 2'd0, 1'b1);
        cycle(1'b1, 1'b1, 5'd21, 32'h66, 1'b0, 3'd0, 2'd0, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("rst_we", {31'b0, wEnable}, 32'd0);
        chk("rst_ready", {31'b0, inReady}, 32'd1);
        chk("rst_addr", {27'b0, wAddr}, 32'd0);
        chk("rst_data", wData, 32'd0);
        chk("rst_instret", instret, 32'd0);
        chk("rst_mis", {31'b0, loadMisalign}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mq.delete(); m_instret = 0; m_mis = 0;
        idle(1'b0);
        chk("post_rst_we", {31'b0, s_we}, 32'd0);
        idle(1'b0);

        // Randomized traffic against the queue model.
        for (int n = 0; n < 400; n++) begin
            cycle(1'($urandom_range(0, 2) != 0), 1'($urandom), 5'($urandom),
                  $urandom, 1'($urandom), 3'($urandom), 2'($urandom),
                  1'($urandom_range(0, 3) == 0));
        end
        repeat (3) idle(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
